// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory fetch, a single-entry
// instruction holding register toward the core, and redirect (flush) handling.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic [31:0] pc,
    output logic [31:0] cmd,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        inst_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] cmd_nxt;
    logic        fault_nxt;
    logic        misaligned;

    assign misaligned   = (pc[1:0] != 2'b00);
    assign mem_req_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset here is synchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            cmd        <= NOP;
            inst_fault <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            cmd        <= cmd_nxt;
            inst_fault <= fault_nxt;
        end
    end

    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cmd_nxt   = cmd;
        fault_nxt = inst_fault;
        case (state)
            REQ: begin
                if (flush) begin
                    // An accepted request is still in flight; its response must be dropped.
                    pc_nxt    = flush_pc;
                    state_nxt = (!misaligned && mem_req_ready) ? DRAIN : REQ;
                end else if (misaligned) begin
                    state_nxt = HOLD;
                    cmd_nxt   = NOP;
                    fault_nxt = 1'b1;
                end else if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_nxt    = flush_pc;
                    state_nxt = mem_rsp_valid ? REQ : DRAIN;
                end else if (mem_rsp_valid) begin
                    state_nxt = HOLD;
                    cmd_nxt   = mem_rsp_err ? NOP : mem_rsp_data;
                    fault_nxt = mem_rsp_err;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_nxt    = flush_pc;
                    state_nxt = REQ;
                end else if (inst_ready) begin
                    pc_nxt    = next_pc;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (flush) begin
                    pc_nxt = flush_pc;
                end
                if (mem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;
        if (!rst) begin
            mem_req_valid = (state == REQ) && !misaligned;
            inst_valid    = (state == HOLD);
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed vector table, a zero-wait throughput
// run, and randomized traffic checked against a transaction-level model.
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic [31:0] pc;
    logic [31:0] cmd;
    logic        inst_valid;
    logic        inst_ready;
    logic        inst_fault;

    int errors = 0;
    int checks = 0;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pc      (next_pc),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_err  (mem_rsp_err),
        .pc           (pc),
        .cmd          (cmd),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_fault   (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] flush_pc;
        logic [31:0] next_pc;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        rsp_err;
        logic        inst_ready;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic        e_inst_valid;
        logic [31:0] e_pc;
        logic [31:0] e_cmd;
        logic        e_fault;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] mem_q[$];
    logic [31:0] exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic f, input logic [31:0] fpc,
                               input logic [31:0] npc, input logic rdy, input logic rv,
                               input logic [31:0] d, input logic e, input logic ir,
                               input logic erv, input logic [31:0] era, input logic eiv,
                               input logic [31:0] epc, input logic [31:0] ecmd, input logic ef);
        vec_t t;
        t.rst = r; t.flush = f; t.flush_pc = fpc; t.next_pc = npc;
        t.req_ready = rdy; t.rsp_valid = rv; t.rsp_data = d; t.rsp_err = e; t.inst_ready = ir;
        t.e_req_valid = erv; t.e_req_addr = era; t.e_inst_valid = eiv;
        t.e_pc = epc; t.e_cmd = ecmd; t.e_fault = ef;
        return t;
    endfunction

    // Memory image: contents and bus-error map are pure functions of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[6:2] == 5'h1F;
    endfunction

    function automatic logic [31:0] rand_addr(input int p_mis);
        logic [31:0] a;
        a = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 99) < p_mis) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic apply_reset();
        rst = 1'b1; flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_q.delete();
        exp_pc = RESET_PC;
    endtask

    // Random traffic: memory answers in order, core accepts at random, flushes and
    // resets interleave; every delivered instruction must match the address the
    // core most recently asked for.
    task automatic run_traffic(input string tag, input int n, input int p_rdy, input int p_rsp,
                               input int p_ir, input int p_flush, input int p_rst,
                               input int p_mis, output int hs_count);
        logic rsp_now, acc, hs, efault;
        logic [31:0] ecmd;
        hs_count = 0;
        for (int c = 0; c < n; c++) begin
            rst           = ($urandom_range(0, 99) < p_rst);
            flush         = ($urandom_range(0, 99) < p_flush);
            flush_pc      = rand_addr(p_mis);
            next_pc       = rand_addr(p_mis);
            mem_req_ready = ($urandom_range(0, 99) < p_rdy);
            inst_ready    = ($urandom_range(0, 99) < p_ir);
            rsp_now       = (mem_q.size() != 0) && ($urandom_range(0, 99) < p_rsp);
            mem_rsp_valid = rsp_now;
            mem_rsp_data  = rsp_now ? mem_word(mem_q[0]) : $urandom;
            mem_rsp_err   = rsp_now ? mem_err(mem_q[0]) : 1'b0;
            #1;
            if (rst) begin
                check($sformatf("%s c%0d req_valid_in_rst", tag, c), 32'(mem_req_valid), 32'd0);
                check($sformatf("%s c%0d inst_valid_in_rst", tag, c), 32'(inst_valid), 32'd0);
            end else begin
                if (mem_req_valid) begin
                    check($sformatf("%s c%0d req_addr", tag, c), mem_req_addr, exp_pc);
                    check($sformatf("%s c%0d req_align", tag, c), 32'(mem_req_addr[1:0]), 32'd0);
                end
                if (inst_valid) begin
                    efault = (exp_pc[1:0] != 2'b00) || mem_err(exp_pc);
                    ecmd   = efault ? NOP : mem_word(exp_pc);
                    check($sformatf("%s c%0d pc", tag, c), pc, exp_pc);
                    check($sformatf("%s c%0d cmd", tag, c), cmd, ecmd);
                    check($sformatf("%s c%0d fault", tag, c), 32'(inst_fault), 32'(efault));
                end
                if (mem_req_valid && inst_valid)
                    check($sformatf("%s c%0d req_and_inst", tag, c), 32'd1, 32'd0);
            end
            acc = mem_req_valid && mem_req_ready;
            hs  = inst_valid && inst_ready;
            @(posedge clk);
            if (rst) begin
                mem_q.delete();
                exp_pc = RESET_PC;
            end else begin
                if (rsp_now) void'(mem_q.pop_front());
                if (acc) mem_q.push_back(mem_req_addr);
                if (flush) exp_pc = flush_pc;
                else if (hs) begin
                    exp_pc = next_pc;
                    hs_count++;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int hs;
        rst = 1'b1; next_pc = '0; flush = 1'b0; flush_pc = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; inst_ready = 1'b0;
        exp_pc = RESET_PC;

        //            r f fpc           npc           rdy rv data          e ir | erv era           eiv epc           ecmd          ef
        vecs.push_back(v(1,0,0,            0,            0,0,0,            0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(1,0,0,            0,            0,0,0,            0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0000,0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,1,32'h0000_0297,0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,0,0,            0,0,  0,0,            1,32'h8000_0000,32'h0000_0297,0));
        vecs.push_back(v(0,0,0,            0,            0,0,0,            0,0,  0,0,            1,32'h8000_0000,32'h0000_0297,0));
        vecs.push_back(v(0,0,0,            0,            0,0,0,            0,0,  0,0,            1,32'h8000_0000,32'h0000_0297,0));
        vecs.push_back(v(0,0,0,            32'h8000_0010,0,0,0,            0,1,  0,0,            1,32'h8000_0000,32'h0000_0297,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0,0,0,        0,            0,0,0,            0,0,  1,32'h8000_0010,0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0010,0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,1,32'h1234_5678,1,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            32'h8000_0006,0,0,0,            0,1,  0,0,            1,32'h8000_0010,NOP,          1));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            32'h8000_0020,0,0,0,            0,1,  0,0,            1,32'h8000_0006,NOP,          1));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0020,0,0,            0,            0));
        vecs.push_back(v(0,1,32'h8000_0100,0,            0,0,0,            0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,1,32'hDEAD_BEEF,0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0100,0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,1,32'h0040_0093,0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,1,32'h8000_0200,0,            0,0,0,            0,1,  0,0,            1,32'h8000_0100,32'h0040_0093,0));
        vecs.push_back(v(0,1,32'h8000_0300,0,            0,0,0,            0,0,  1,32'h8000_0200,0,0,            0,            0));
        vecs.push_back(v(0,1,32'h8000_0400,0,            1,0,0,            0,0,  1,32'h8000_0300,0,0,            0,            0));
        vecs.push_back(v(0,1,32'h8000_0500,0,            0,0,0,            0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,1,32'hBAD0_0001,0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0500,0,0,            0,            0));
        vecs.push_back(v(0,1,32'h8000_0600,0,            0,1,32'hBAD0_0002,0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0600,0,0,            0,            0));
        vecs.push_back(v(1,1,32'h8000_0700,0,            0,0,0,            0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,0,0,            0,0,  1,32'h8000_0000,0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            1,0,0,            0,0,  1,32'h8000_0000,0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,1,32'h0000_0297,0,0,  0,0,            0,0,            0,            0));
        vecs.push_back(v(0,0,0,            0,            0,0,0,            0,0,  0,0,            1,32'h8000_0000,32'h0000_0297,0));

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; flush = vecs[i].flush; flush_pc = vecs[i].flush_pc;
            next_pc = vecs[i].next_pc; mem_req_ready = vecs[i].req_ready;
            mem_rsp_valid = vecs[i].rsp_valid; mem_rsp_data = vecs[i].rsp_data;
            mem_rsp_err = vecs[i].rsp_err; inst_ready = vecs[i].inst_ready;
            #1;
            check($sformatf("vec%0d req_valid", i), 32'(mem_req_valid), 32'(vecs[i].e_req_valid));
            check($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_inst_valid));
            if (vecs[i].e_req_valid)
                check($sformatf("vec%0d req_addr", i), mem_req_addr, vecs[i].e_req_addr);
            if (vecs[i].e_inst_valid) begin
                check($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
                check($sformatf("vec%0d cmd", i), cmd, vecs[i].e_cmd);
                check($sformatf("vec%0d fault", i), 32'(inst_fault), 32'(vecs[i].e_fault));
            end
            @(negedge clk);
        end

        // Zero-wait memory and an always-ready core: one instruction every 3 cycles.
        apply_reset();
        run_traffic("thru", 30, 100, 100, 100, 0, 0, 0, hs);
        check("throughput", 32'(hs), 32'd10);

        apply_reset();
        run_traffic("rand", 3000, 70, 60, 60, 8, 1, 10, hs);
        if (hs < 50) check("rand_progress", 32'(hs), 32'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
